// File: rtl/axil_reg_writer.sv
// AXI4-Lite master: each (index, data) command becomes one single-beat write at C_BASE_ADDR + 4*index.
// Define AXIL_REG_WRITER_READBACK_EN to read the register back and compare it after each write.
module axil_reg_writer #(
  parameter int                          C_AXI_ADDR_WIDTH = 32,
  parameter int                          C_AXI_DATA_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = 32'h0000_0000,
  parameter int                          C_NUM_REGS       = 4,
  parameter int                          C_IDX_WIDTH      = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [C_IDX_WIDTH-1:0]        cmd_idx,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_data,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    last_resp,
  output logic [7:0]                    err_count,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
`ifdef AXIL_REG_WRITER_READBACK_EN
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
`endif
    ST_DONE    = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic                          cmd_ready_q, cmd_ready_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          bready_q, bready_d;
  logic [1:0]                    last_resp_q, last_resp_d;
  logic [7:0]                    err_count_q, err_count_d;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_AXI_DATA_WIDTH-1:0]   data_q, data_d;
  logic                          idx_ok_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign idx_ok_s = (32'(cmd_idx) < 32'(C_NUM_REGS));

`ifdef AXIL_REG_WRITER_READBACK_EN
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic rd_mismatch_s;
  assign rd_mismatch_s = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_q);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
`else
  logic unused_rd_s;
  assign unused_rd_s   = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
  assign M_AXI_ARADDR  = {C_AXI_ADDR_WIDTH{1'b0}};
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
`endif

  // Next-state and next-output logic for the command sequencer
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    last_resp_d = last_resp_q;
    err_count_d = err_count_q;
    addr_d      = addr_q;
    data_d      = data_q;
`ifdef AXIL_REG_WRITER_READBACK_EN
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          data_d      = cmd_data;
          addr_d      = C_BASE_ADDR + C_AXI_ADDR_WIDTH'({cmd_idx, 2'b00});
          if (idx_ok_s) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_ADDR;
          end else begin
            last_resp_d = 2'b10;
            err_count_d = sat_inc(err_count_q);
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_WR_ADDR: begin
        // AW and W retire independently; leave only once both are gone
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        else                            awvalid_d = awvalid_q;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d = 1'b0;
        else                            wvalid_d = wvalid_q;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else begin
          state_d  = ST_WR_ADDR;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          last_resp_d = M_AXI_BRESP;
          if (M_AXI_BRESP != 2'b00) err_count_d = sat_inc(err_count_q);
          else                      err_count_d = err_count_q;
`ifdef AXIL_REG_WRITER_READBACK_EN
          arvalid_d = 1'b1;
          state_d   = ST_RD_ADDR;
`else
          done_d    = 1'b1;
          state_d   = ST_DONE;
`endif
        end else begin
          state_d = ST_WR_RESP;
        end
      end
`ifdef AXIL_REG_WRITER_READBACK_EN
      ST_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else begin
          state_d   = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          // A write error already reported takes precedence over the readback result
          if (rd_mismatch_s && (last_resp_q == 2'b00)) begin
            err_count_d = sat_inc(err_count_q);
            last_resp_d = 2'b10;
          end else begin
            err_count_d = err_count_q;
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
`endif
      ST_DONE: begin
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
`ifdef AXIL_REG_WRITER_READBACK_EN
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
`endif
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      last_resp_q <= 2'b00;
      err_count_q <= 8'h00;
      addr_q      <= {C_AXI_ADDR_WIDTH{1'b0}};
      data_q      <= {C_AXI_DATA_WIDTH{1'b0}};
`ifdef AXIL_REG_WRITER_READBACK_EN
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      last_resp_q <= last_resp_d;
      err_count_q <= err_count_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
`ifdef AXIL_REG_WRITER_READBACK_EN
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign last_resp     = last_resp_q;
  assign err_count     = err_count_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = {(C_AXI_DATA_WIDTH/8){1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARPROT  = 3'b000;

endmodule

// File: doc/axil_reg_writer.md
Name: axil_reg_writer

Overview:
AXI4-Lite master engine that sits directly upstream of the AXI output-register slave in the dense-frontier design. It accepts (register index, data) commands on a valid/ready port and turns each one into a single-beat AXI4-Lite write at C_BASE_ADDR + 4*index. It reports the completion status of each write. With the optional feature compiled in, it reads the register back and checks the value, which gives a hardware version of the write-then-readback sequence.

Parameters:
C_AXI_ADDR_WIDTH, 32, AXI address width
C_AXI_DATA_WIDTH, 32, AXI data width (fixed 32; WSTRB = 4'hF)
C_BASE_ADDR, 32'h0000_0000, slave base address
C_NUM_REGS, 4, number of valid register indices
C_IDX_WIDTH, 2, width of cmd_idx

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_idx  in  C_IDX_WIDTH  target register index
cmd_data  in  32  write data
busy  out  1  high from command acceptance until done pulse
done  out  1  one-cycle pulse when a command completes
last_resp  out  2  final response of the last command
err_count  out  8  saturating error counter
M_AXI_AWADDR/AWPROT/AWVALID  out  32/3/1  write address channel; AWPROT = 3'b000
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WVALID  out  32/4/1  write data channel
M_AXI_WREADY  in  1
M_AXI_BRESP/BVALID  in  2/1; M_AXI_BREADY out 1
M_AXI_ARADDR/ARPROT/ARVALID  out  32/3/1; M_AXI_ARREADY in 1
M_AXI_RDATA/RRESP/RVALID  in  32/2/1; M_AXI_RREADY out 1

Behaviour:
- Reset is asynchronous and active-low (ARESETN). While reset is asserted, all outputs are 0: cmd_ready, busy, done, last_resp, err_count, every VALID and READY, and all address/data registers. Reset in the middle of a transaction drops every VALID immediately and returns the FSM to IDLE. No transaction is resumed after reset.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE. RD_* states exist only when the optional feature is compiled in.
- IDLE:
  - cmd_ready = 1 (registered; asserted the first cycle after reset release).
  - On cmd_valid & cmd_ready: latch idx and data, set busy.
  - If idx < C_NUM_REGS: go to WR_ADDR.
  - Otherwise: issue no bus access, set last_resp = 2'b10, increment err_count, go to DONE.
- WR_ADDR:
  - AWVALID and WVALID are both asserted in the cycle after acceptance, with AWADDR = C_BASE_ADDR + {idx,2'b00}.
  - Each VALID deasserts independently on its own handshake. AW and W may complete in either order or in the same cycle.
  - VALID, ADDR and DATA are held stable until the handshake.
  - When both have completed, go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: capture BRESP into last_resp. If BRESP != 2'b00, increment err_count.
  - Then go to DONE, or to RD_ADDR if the feature is compiled in.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE. This gives a minimum of 2 idle cycles between back-to-back commands.
- Latency with no AXI back-pressure: acceptance at cycle 0, AW/W handshake at cycle 1, B at cycle 2 at the earliest, done at cycle 3.
- err_count saturates at 8'hFF and does not wrap.
- BVALID or RVALID arriving outside the matching state is ignored, because READY is low.

Optional Feature:
- Macro: AXIL_REG_WRITER_READBACK_EN.
- When defined, after WR_RESP the block reads the register back:
  - RD_ADDR: ARVALID = 1 with ARADDR = AWADDR, held until ARREADY.
  - RD_DATA: RREADY = 1. On RVALID, a mismatch is RRESP != OKAY or RDATA != the latched data.
  - On mismatch: increment err_count and set last_resp = 2'b10, unless BRESP already signalled an error.
  - Then go to DONE. Adds at least 2 cycles of latency.
- When not defined: ARVALID, ARADDR and RREADY are tied to 0, the RD_* states are absent, and R-channel inputs are ignored.

Test Plan:
- Write idx 0..3 with 32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011 to an always-ready slave. Required: AWADDR 0x0, 0x4, 0x8, 0xC; slave registers hold those values; 4 done pulses; last_resp = 0; err_count = 0.
- Slave holds WREADY low for 5 cycles after AWREADY. Required: WVALID and WDATA stay stable, AWVALID drops after its handshake, and exactly one B is accepted.
- Command with idx = 3 and C_NUM_REGS = 3. Required: no AWVALID, done after 1 cycle, last_resp = 2'b10, err_count = 1.
- Slave returns BRESP = 2'b10 on 256 writes. Required: err_count saturates at 8'hFF.
- Assert ARESETN low while AWVALID is high. Required: all VALIDs are 0 in the same cycle. After release, a new command writes normally.
- With the readback macro defined, the slave returns RDATA = 32'h0 after writing 32'hDEAD0011. Required: last_resp = 2'b10 and err_count increments. A matching readback leaves err_count unchanged.
